risc16_uart_loader: RTL

// - Boot-time program loader upstream of risc16p.
// - Receives a program image over an 8N1 UART and writes it byte-by-byte into the

---
 rtl/risc16_uart_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/risc16_uart_loader.sv
// UART boot loader: receives an A5/LEN/data image, writes it to memory, then releases risc16p.
// Optional LOADER_CHECKSUM_EN: trailing 8-bit sum byte must match before the CPU is released.
module risc16_uart_loader #(
    parameter int          CLK_HZ    = 25_000_000,
    parameter int          BAUD      = 115200,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    rx_state_t     rx_st;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_valid, rx_ferr;

    state_t        st, st_nxt;
    logic [7:0]    len_hi;
    logic [15:0]   remaining;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    // UART receiver; rx_sh holds the finished byte while rx_valid is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_st    <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_cnt   <= rx_cnt + 1'b1;
            case (rx_st)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_st <= RX_START;
                end
                RX_START: if (rx_cnt == CW'(HALF - 1)) begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_st  <= rx_s2 ? RX_IDLE : RX_BITS;
                end
                RX_BITS: if (rx_cnt == CW'(DIV - 1)) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_st <= RX_STOP;
                end
                RX_STOP: if (rx_cnt == CW'(DIV - 1)) begin
                    rx_valid <= rx_s2;
                    rx_ferr  <= !rx_s2;
                    rx_st    <= RX_IDLE;
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= ST_WAIT_MAGIC;
        else      st <= st_nxt;
    end

    always_comb begin
        st_nxt  = st;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        cpu_rst = 1'b1;
        case (st)
            ST_WAIT_MAGIC: if (rx_valid && rx_sh == 8'hA5) st_nxt = ST_LEN_H;
            ST_LEN_H: begin
                busy = 1'b1;
                if (rx_valid) st_nxt = ST_LEN_L;
            end
            ST_LEN_L: begin
                busy = 1'b1;
                if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    st_nxt = ({len_hi, rx_sh} == 16'd0) ? ST_CHK : ST_DATA;
`else
                    st_nxt = ({len_hi, rx_sh} == 16'd0) ? ST_DONE : ST_DATA;
`endif
                end
            end
            // leave DATA on the last write strobe so done follows it by one clock
            ST_DATA: begin
                busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                if (mem_we && remaining == 16'd1) st_nxt = ST_CHK;
`else
                if (mem_we && remaining == 16'd1) st_nxt = ST_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                busy = 1'b1;
                if (rx_valid) st_nxt = (rx_sh == sum) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ST_ERROR: err = 1'b1;
            default:  st_nxt = ST_ERROR;
        endcase
        if (rx_ferr && st != ST_DONE && st != ST_ERROR) st_nxt = ST_ERROR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            len_hi    <= '0;
            remaining <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (st)
`ifdef LOADER_CHECKSUM_EN
                ST_WAIT_MAGIC: if (rx_valid) sum <= '0;
`endif
                ST_LEN_H: if (rx_valid) len_hi <= rx_sh;
                ST_LEN_L: if (rx_valid) begin
                    remaining <= {len_hi, rx_sh};
                    mem_addr  <= BASE_ADDR;
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= rx_sh;
`ifdef LOADER_CHECKSUM_EN
                        sum       <= sum + rx_sh;
`endif
                    end
                    if (mem_we) begin
                        mem_addr  <= mem_addr + 16'd1;
                        remaining <= remaining - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
